// File: rtl/fan_tach_pkg.sv
// Shared types and helpers for the fan tachometer monitor.
package fan_tach_pkg;
   typedef logic [15:0] rpm_t;
   localparam rpm_t RPM_MAX = 16'hFFFF;

   function automatic rpm_t sat_inc(rpm_t v);
      return (v == RPM_MAX) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/fan_tach_monitor_tach_channel.sv
// One tach channel: 2-FF synchroniser, deglitch filter, falling-edge detect
// and a saturating edge counter that is cleared by the shared gate pulse.
module tach_channel
   import fan_tach_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tach,
   input  logic clr,
   output rpm_t edge_cnt
);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   logic           sync1;
   logic           sync2;
   logic           filt;
   logic [DBW-1:0] db_cnt;
   logic           flip;
   logic           fall;

   // The Nth consecutive differing sample flips the filtered level.
   assign flip = (sync2 != filt) && (db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
   assign fall = flip && filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         filt     <= 1'b1;
         db_cnt   <= '0;
         edge_cnt <= '0;
      end else begin
         sync1 <= tach;
         sync2 <= sync1;
         if (sync2 == filt) begin
            db_cnt <= '0;
         end else if (flip) begin
            filt   <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DBW'(1);
         end
         // An edge on the clearing cycle belongs to the new window.
         if (clr) begin
            edge_cnt <= fall ? 16'd1 : 16'd0;
         end else if (fall) begin
            edge_cnt <= sat_inc(edge_cnt);
         end
      end
   end
endmodule

// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor: shared gate window, per-fan edge counts scaled to RPM.
// Optional stall detection is built when FAN_TACH_STALL_DETECT_EN is defined.
module fan_tach_monitor
   import fan_tach_pkg::*;
#(
   parameter int NUM_FANS        = 2,
   parameter int GATE_CYCLES     = 125000000,
   parameter int RPM_SCALE       = 60,
   parameter int DEBOUNCE_CYCLES = 8
`ifdef FAN_TACH_STALL_DETECT_EN
   ,
   parameter int STALL_WINDOWS   = 3
`endif
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_FANS-1:0]      tach,
   output logic [16*NUM_FANS-1:0]   fan_rpm,
   output logic                     rpm_valid,
   output logic                     rpm_update,
   output logic [NUM_FANS-1:0]      fan_stall
);
   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int PW = 16 + $clog2(RPM_SCALE + 1);

   logic [GW-1:0] gate;
   logic          term;
   rpm_t          edge_cnt [NUM_FANS];

   assign term = (gate == GW'(GATE_CYCLES - 1));

   function automatic rpm_t scale(rpm_t cnt);
      logic [PW-1:0] prod;
      prod = PW'(cnt) * PW'(RPM_SCALE);
      return (prod > PW'(RPM_MAX)) ? RPM_MAX : prod[15:0];
   endfunction

   for (genvar g = 0; g < NUM_FANS; g++) begin : g_ch
      tach_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .tach     (tach[g]),
         .clr      (term),
         .edge_cnt (edge_cnt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate       <= '0;
         fan_rpm    <= '0;
         rpm_valid  <= 1'b0;
         rpm_update <= 1'b0;
      end else begin
         rpm_update <= term;
         if (term) begin
            gate      <= '0;
            rpm_valid <= 1'b1;
            for (int i = 0; i < NUM_FANS; i++) begin
               fan_rpm[16*i +: 16] <= scale(edge_cnt[i]);
            end
         end else begin
            gate <= gate + GW'(1);
         end
      end
   end

`ifdef FAN_TACH_STALL_DETECT_EN
   localparam int SW = $clog2(STALL_WINDOWS + 1);

   logic [SW-1:0]       stall_cnt [NUM_FANS];
   logic [NUM_FANS-1:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         for (int i = 0; i < NUM_FANS; i++) begin
            stall_cnt[i] <= '0;
         end
      end else if (term) begin
         for (int i = 0; i < NUM_FANS; i++) begin
            if (edge_cnt[i] == 16'd0) begin
               if (stall_cnt[i] != SW'(STALL_WINDOWS)) begin
                  stall_cnt[i] <= stall_cnt[i] + SW'(1);
               end
               // Flag on the window that brings the count to the limit.
               stall_q[i] <= (stall_cnt[i] >= SW'(STALL_WINDOWS - 1));
            end else begin
               stall_cnt[i] <= '0;
               stall_q[i]   <= 1'b0;
            end
         end
      end
   end

   assign fan_stall = stall_q;
`else
   assign fan_stall = '0;
`endif
endmodule

// File: tb/tb_fan_tach_monitor.sv
// Scoreboard bench for fan_tach_monitor with a window-level reference model.
module tb_fan_tach_monitor;
   localparam int NF     = 2;
   localparam int GATE   = 1000;
   localparam int SCALE  = 60;
   localparam int DEB    = 4;
   localparam int STALLW = 3;
`ifdef FAN_TACH_STALL_DETECT_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   localparam int M_HIGH = 0, M_SQ = 1, M_GLITCH = 2, M_PULSE = 3, M_TERM = 4, M_RAND = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  tach, tach_sat;
   logic [31:0] fan_rpm, sat_rpm;
   logic        rpm_valid, rpm_update, sat_valid, sat_update;
   logic [1:0]  fan_stall, sat_stall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fan_tach_monitor #(
      .NUM_FANS(NF), .GATE_CYCLES(GATE), .RPM_SCALE(SCALE), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tach(tach), .fan_rpm(fan_rpm),
      .rpm_valid(rpm_valid), .rpm_update(rpm_update), .fan_stall(fan_stall)
   );

   fan_tach_monitor #(
      .NUM_FANS(NF), .GATE_CYCLES(GATE), .RPM_SCALE(1000), .DEBOUNCE_CYCLES(DEB)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .tach(tach_sat), .fan_rpm(sat_rpm),
      .rpm_valid(sat_valid), .rpm_update(sat_update), .fan_stall(sat_stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] rpm;
      logic [1:0]  stall;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   int          win_edges [NF];
   int          zero_run  [NF];
   logic        mfilt     [NF];
   logic [15:0] hist      [NF];   // hist[k] = raw sample taken k+1 posedges ago

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0;
         q.delete();
         for (int i = 0; i < NF; i++) begin
            win_edges[i] = 0;
            zero_run[i]  = 0;
            mfilt[i]     = 1'b1;
            hist[i]      = '1;
         end
      end else begin
         bit   fell [NF];
         exp_t e;
         for (int i = 0; i < NF; i++) begin
            bit all_diff;
            // Filter sees samples two cycles late; needs DEB differing in a row.
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (hist[i][1+j] == mfilt[i]) all_diff = 1'b0;
            fell[i] = all_diff && mfilt[i];
            if (all_diff) mfilt[i] = ~mfilt[i];
            hist[i] = {hist[i][14:0], tach[i]};
         end
         if (cyc % GATE == GATE - 1) begin
            e.rpm   = '0;
            e.stall = '0;
            for (int i = 0; i < NF; i++) begin
               int p;
               p = win_edges[i] * SCALE;
               e.rpm[16*i +: 16] = (p > 65535) ? 16'hFFFF : 16'(p);
               zero_run[i] = (win_edges[i] == 0) ? zero_run[i] + 1 : 0;
               e.stall[i]  = STALL_ON && (zero_run[i] >= STALLW);
               win_edges[i] = fell[i] ? 1 : 0;
            end
            q.push_back(e);
         end else begin
            for (int i = 0; i < NF; i++)
               if (fell[i] && win_edges[i] < 65535) win_edges[i]++;
         end
         cyc++;
      end
   end

   // ---------------- monitor ----------------
   logic [31:0] last_rpm;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_rpm = '0;
      end else begin
         if (rpm_update) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_update: actual=1 required=0 at cyc %0d", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_fan_rpm", fan_rpm, e.rpm);
               chk("sb_fan_stall", 32'(fan_stall), 32'(e.stall));
               chk("sb_rpm_valid", 32'(rpm_valid), 32'd1);
            end
         end else begin
            if (q.size() != 0) begin
               void'(q.pop_front());
               tests++;
               fails++;
               $display("FAIL missing_update: actual=0 required=1 at cyc %0d", cyc);
            end
            chk("rpm_stable", fan_rpm, last_rpm);
         end
         last_rpm = fan_rpm;
      end
   end

   // ---------------- stimulus ----------------
   int   mode [NF];
   int   hp   [NF];
   int   ph   [NF];
   int   glen [NF];
   logic lvl  [NF];
   int   sat_ph;

   task automatic set_mode(input int i, input int m, input int h, input int g);
      mode[i] = m;
      hp[i]   = h;
      glen[i] = g;
      ph[i]   = 0;
      lvl[i]  = 1'b1;
   endtask

   task automatic gen();
      for (int i = 0; i < NF; i++) begin
         case (mode[i])
            M_SQ: begin
               tach[i] = (ph[i] < hp[i]);
               ph[i]   = (ph[i] + 1) % (2 * hp[i]);
            end
            M_GLITCH: begin
               tach[i] = !(ph[i] >= 50 - glen[i]);
               ph[i]   = (ph[i] + 1) % 50;
            end
            M_PULSE: begin
               tach[i] = !(ph[i] >= 300 && ph[i] < 300 + glen[i]);
               if (ph[i] < 2000) ph[i]++;
            end
            M_TERM: begin
               // Raw low lands so the filtered fall hits the terminal cycle.
               if (ph[i] == 0) begin
                  tach[i] = 1'b1;
                  if ((cyc - 1) % GATE == GATE - 1 - (DEB + 2)) begin
                     tach[i] = 1'b0;
                     ph[i]   = 1;
                  end
               end else if (ph[i] < 50) begin
                  tach[i] = 1'b0;
                  ph[i]++;
               end else begin
                  tach[i] = 1'b1;
               end
            end
            M_RAND: begin
               if (ph[i] >= hp[i]) begin
                  lvl[i] = ~lvl[i];
                  ph[i]  = 0;
                  hp[i]  = int'($urandom_range(4, 40));
               end
               ph[i]++;
               tach[i] = lvl[i] ^ ($urandom_range(0, 59) == 0);
            end
            default: tach[i] = 1'b1;
         endcase
      end
      tach_sat[0] = (sat_ph < 4);
      tach_sat[1] = 1'b1;
      sat_ph = (sat_ph + 1) % 8;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1 gen();
      @(negedge clk);
   endtask

   task automatic wait_upd(output int n);
      n = 0;
      forever begin
         cycle();
         n++;
         if (rpm_update) break;
         if (n >= 1500) begin
            tests++;
            fails++;
            $display("FAIL update_timeout: actual=none required=update within 1500 cycles");
            break;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_fan_rpm"}, fan_rpm, 32'd0);
      chk({tag, "_rpm_valid"}, 32'(rpm_valid), 32'd0);
      chk({tag, "_rpm_update"}, 32'(rpm_update), 32'd0);
      chk({tag, "_fan_stall"}, 32'(fan_stall), 32'd0);
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      tach     = '1;
      tach_sat = '1;
      sat_ph   = 0;
      for (int i = 0; i < NF; i++) set_mode(i, M_HIGH, 1, 0);

      repeat (3) @(posedge clk);
      #1 chk_reset_outputs("reset");

      // Release, fan0 100-clk square, fan1 idle high.
      @(posedge clk);
      #1 rst_n = 1'b1;
      set_mode(0, M_SQ, 50, 0);
      gen();
      @(negedge clk);

      wait_upd(n);
      chk("first_update_latency", 32'(n), 32'd1000);
      chk("win1_fan0_rpm", 32'(fan_rpm[15:0]), 32'd600);
      chk("win1_fan1_rpm", 32'(fan_rpm[31:16]), 32'd0);
      chk("sat_fan0_rpm", 32'(sat_rpm[15:0]), 32'hFFFF);
      chk("sat_update_aligned", 32'(sat_update), 32'd1);

      wait_upd(n);
      chk("update_period", 32'(n), 32'd1000);
      chk("win2_fan0_rpm", 32'(fan_rpm[15:0]), 32'd600);
      chk("win2_fan1_stall", 32'(fan_stall[1]), 32'd0);
      chk("sat_win2_fan0_rpm", 32'(sat_rpm[15:0]), 32'hFFFF);

      wait_upd(n);
      chk("win3_fan1_stall", 32'(fan_stall[1]), 32'(STALL_ON));
      chk("win3_valid_sticky", 32'(rpm_valid), 32'd1);

      // Fan1 resumes toggling: stall clears at the next update.
      set_mode(1, M_SQ, 30, 0);
      wait_upd(n);
      chk("resume_fan1_stall", 32'(fan_stall[1]), 32'd0);

      // Short glitches on idle-high fan0 must not count.
      set_mode(0, M_GLITCH, 1, 2);
      wait_upd(n);
      wait_upd(n);
      chk("glitch_fan0_rpm", 32'(fan_rpm[15:0]), 32'd0);

      // A single DEB-long low pulse counts one edge.
      set_mode(0, M_PULSE, 1, DEB);
      wait_upd(n);
      chk("pulse_fan0_rpm", 32'(fan_rpm[15:0]), 32'd60);

      // Filtered fall exactly on the terminal cycle.
      set_mode(0, M_TERM, 1, 0);
      wait_upd(n);
      chk("term_edge_old_window", 32'(fan_rpm[15:0]), 32'd0);
      wait_upd(n);
      chk("term_edge_new_window", 32'(fan_rpm[15:0]), 32'd60);

      // Randomised waveforms on both fans.
      set_mode(0, M_RAND, int'($urandom_range(4, 40)), 0);
      set_mode(1, M_RAND, int'($urandom_range(4, 40)), 0);
      for (int w = 0; w < 5; w++) wait_upd(n);

      // Reset halfway through a window.
      repeat (500) cycle();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      set_mode(0, M_SQ, 50, 0);
      gen();
      @(negedge clk);
      wait_upd(n);
      chk("post_reset_latency", 32'(n), 32'd1000);
      chk("post_reset_fan0_rpm", 32'(fan_rpm[15:0]), 32'd600);
      wait_upd(n);

      repeat (20) cycle();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
